ow_phy_arbiter: RTL
===================

# ow_phy_arbiter

Round-robin transaction arbiter between NUM_REQ host requesters and the single one-wire PHY. Accepts a complete command byte stream from one granted requester and presents it to the PHY through a one-entry pop-style FIFO interface (feeding the PHY's write-FIFO port). It then routes the expected number of PHY read bytes back to that same requester, with a response timeout, before re-arbitrating.

## Interface
Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- PHY_FIFO_WIDTH, 8, byte width on all data ports
- RSP_LEN_WIDTH, 6, width of the expected-response-byte count
- TIMEOUT_CYCLES, 65535, idle cycles allowed between response bytes

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester byte valid
- req_data  in  NUM_REQ*PHY_FIFO_WIDTH  per-requester command byte (requester i at slice i)
- req_last  in  NUM_REQ  marks final command byte
- req_rsp_len  in  NUM_REQ*RSP_LEN_WIDTH  expected response bytes; sampled with first accepted byte
- req_ready  out  NUM_REQ  byte accepted when req_valid & req_ready
- phy_fifo_empty  out  1  holding register empty
- phy_fifo_en  in  1  PHY pop strobe
- phy_fifo_data  out  PHY_FIFO_WIDTH  holding register contents
- rd_phy_fifo_en  in  1  PHY read-byte strobe
- rd_phy_fifo_data  in  PHY_FIFO_WIDTH  PHY read byte
- rsp_valid  out  NUM_REQ  one-hot response byte strobe
- rsp_data  out  PHY_FIFO_WIDTH  response byte (shared)
- rsp_last  out  1  final response byte, or timeout pulse
- rsp_timeout  out  1  response timeout pulse (with rsp_last, zero rsp_valid)
- stray_byte  out  1  PHY read byte dropped (not in RSP)
- busy  out  1  state != IDLE
- grant_id  out  clog2(NUM_REQ)  current or last grant

## Operation
- States: IDLE, TX, DRAIN, RSP.
- IDLE: if any req_valid, grant the first requester at or after rr_ptr (wrapping); register grant_id, set rr_ptr = grant+1 mod NUM_REQ; go to TX.
- TX: req_ready[grant] = hold empty OR phy_fifo_en this cycle; all other ready bits 0. Accepted byte loads hold. First accepted byte latches rsp_len. Accepted byte with req_last goes to DRAIN.
- DRAIN: wait for pop of the last byte. Then rsp_len==0 goes to IDLE; otherwise go to RSP, clearing the timeout counter.
- RSP: each rd_phy_fifo_en registers rsp_data and sets rsp_valid[grant] for 1 cycle. It also decrements rsp_len and clears the timer. Reaching 0 sets rsp_last with the byte, then goes to IDLE.
- RSP timeout: with no byte, the timer increments; at TIMEOUT_CYCLES pulse rsp_timeout + rsp_last for 1 cycle, rsp_valid=0, go to IDLE.
- rd_phy_fifo_en outside RSP: byte dropped, stray_byte pulses 1 cycle.
- phy_fifo_en while hold empty: ignored, no state change.
- Requester stalling in TX (req_valid low): wait indefinitely; TX/DRAIN have no timeout.
- Simultaneous pop and accept: hold reloads, stays non-empty.
- Timer width clog2(TIMEOUT_CYCLES+1); rsp_len decrements never underflow.

## Timing
- Reset values: req_ready=0, phy_fifo_empty=1, phy_fifo_data=0, rsp_valid=0, rsp_data=0, rsp_last=0, rsp_timeout=0, stray_byte=0, busy=0, grant_id=0. After reset: rr_ptr=0, hold cleared, state=IDLE.
- Reset mid-operation aborts the transaction with no response and no timeout pulse.
- Latency: req_valid sampled in IDLE at cycle N, then grant/busy at N+1. req_ready high at N+1; byte in hold and phy_fifo_empty=0 at N+2.
- phy_fifo_data is stable while !phy_fifo_empty and the byte has not been popped.
- Response: rd_phy_fifo_en at cycle M gives rsp_valid at M+1.
- Last response byte at M+1 leaves the FSM in IDLE at M+1; next grant is visible at M+2.
- Outputs are registered, except req_ready, which is combinational from state/hold/phy_fifo_en.

## Structure
- Shared package ow_pkg: state enum (IDLE, TX, DRAIN, RSP), PHY_FIFO_WIDTH, RSP_LEN_WIDTH defaults.
- Sub-module ow_rr_arbiter: request vector + rr_ptr -> one-hot grant + encoded id, combinational.

## Test plan
- Single req0, bytes 0xCC,0x44 (last), rsp_len=0; PHY pops each 3 cycles -> phy_fifo_data 0xCC then 0x44; busy drops after the second pop; no rsp activity.
- req0 and req1 both valid from reset -> req0 granted first, req1 second; a third round with both valid grants req0.
- req1 sends 0x33 (last), rsp_len=8; PHY returns 8 bytes 0x01..0x08 -> rsp_valid[1] ×8, rsp_data 0x01..0x08, rsp_last with 0x08, rsp_valid[0] never set.
- rsp_len=2, TIMEOUT_CYCLES=16, only one byte returned -> one rsp_valid, then 16 cycles later rsp_timeout=rsp_last=1, rsp_valid=0, state IDLE.
- rd_phy_fifo_en in IDLE with 0xAA -> stray_byte pulse, no rsp_valid. phy_fifo_en with hold empty -> no change.
- rst asserted mid-RSP after 3 of 5 bytes -> next cycle all outputs at reset values, rr_ptr=0; a subsequent req1-only request is served normally.

Source files
------------

// File: rtl/ow_pkg.sv
// Shared types and default widths for the one-wire PHY arbiter.
package ow_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TX    = 2'd1,
    DRAIN = 2'd2,
    RSP   = 2'd3
  } state_t;

  localparam int PHY_FIFO_WIDTH_DEF = 8;
  localparam int RSP_LEN_WIDTH_DEF  = 6;

endpackage

// File: rtl/ow_rr_arbiter.sv
// Combinational round-robin pick: the first active requester at or after
// rr_ptr, wrapping around, as both one-hot and encoded id.
module ow_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               any_req
);

  // Scan from rr_ptr upward and stop at the first requester found
  always_comb begin
    int idx;
    idx      = 0;
    grant    = '0;
    grant_id = '0;
    any_req  = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = (int'(rr_ptr) + off) % NUM_REQ;
      if (!any_req && req[idx]) begin
        any_req    = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/ow_phy_arbiter.sv
// Round-robin arbiter between host requesters and the single one-wire PHY.
// A granted requester streams its command bytes into a one-entry holding
// register popped by the PHY; the expected number of PHY read bytes is then
// routed back to the same requester, guarded by an inter-byte timeout.
module ow_phy_arbiter
  import ow_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int PHY_FIFO_WIDTH = PHY_FIFO_WIDTH_DEF,
  parameter int RSP_LEN_WIDTH  = RSP_LEN_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = 65535,
  localparam int ID_W          = $clog2(NUM_REQ)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ*PHY_FIFO_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]                req_last,
  input  logic [NUM_REQ*RSP_LEN_WIDTH-1:0]  req_rsp_len,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic                              phy_fifo_empty,
  input  logic                              phy_fifo_en,
  output logic [PHY_FIFO_WIDTH-1:0]         phy_fifo_data,
  input  logic                              rd_phy_fifo_en,
  input  logic [PHY_FIFO_WIDTH-1:0]         rd_phy_fifo_data,
  output logic [NUM_REQ-1:0]                rsp_valid,
  output logic [PHY_FIFO_WIDTH-1:0]         rsp_data,
  output logic                              rsp_last,
  output logic                              rsp_timeout,
  output logic                              stray_byte,
  output logic                              busy,
  output logic [ID_W-1:0]                   grant_id
);

  localparam int                TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ID_W-1:0]   ID_MAX   = ID_W'(NUM_REQ - 1);

  state_t                     state;
  logic [NUM_REQ-1:0]         grant_oh;
  logic [ID_W-1:0]            rr_ptr;
  logic                       first_byte;
  logic [RSP_LEN_WIDTH-1:0]   rsp_len;
  logic [TMR_W-1:0]           timer;

  logic [NUM_REQ-1:0]         arb_grant;
  logic [ID_W-1:0]            arb_id;
  logic                       arb_any;

  logic                       tx_open;
  logic                       accept;
  logic                       pop;
  logic [PHY_FIFO_WIDTH-1:0]  sel_data;
  logic [RSP_LEN_WIDTH-1:0]   sel_len;
  logic                       sel_last;

  ow_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req      (req_valid),
    .rr_ptr   (rr_ptr),
    .grant    (arb_grant),
    .grant_id (arb_id),
    .any_req  (arb_any)
  );

  // The holding register can take a byte when empty or when it is being
  // popped in the same cycle, which keeps the stream at one byte per cycle.
  assign tx_open   = (state == TX) && (phy_fifo_empty || phy_fifo_en);
  assign req_ready = tx_open ? grant_oh : '0;
  assign accept    = |(req_valid & req_ready);
  assign pop       = phy_fifo_en && !phy_fifo_empty;
  assign sel_data  = req_data[int'(grant_id)*PHY_FIFO_WIDTH +: PHY_FIFO_WIDTH];
  assign sel_len   = req_rsp_len[int'(grant_id)*RSP_LEN_WIDTH +: RSP_LEN_WIDTH];
  assign sel_last  = req_last[grant_id];

  // Transaction FSM with holding register and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      grant_oh       <= '0;
      rr_ptr         <= '0;
      first_byte     <= 1'b0;
      phy_fifo_empty <= 1'b1;
      phy_fifo_data  <= '0;
      rsp_valid      <= '0;
      rsp_data       <= '0;
      rsp_last       <= 1'b0;
      rsp_timeout    <= 1'b0;
      stray_byte     <= 1'b0;
      busy           <= 1'b0;
      grant_id       <= '0;
    end else begin
      rsp_valid   <= '0;
      rsp_last    <= 1'b0;
      rsp_timeout <= 1'b0;
      stray_byte  <= 1'b0;

      if (accept) begin
        phy_fifo_data  <= sel_data;
        phy_fifo_empty <= 1'b0;
      end else if (pop) begin
        phy_fifo_empty <= 1'b1;
      end

      if (rd_phy_fifo_en && (state != RSP)) begin
        stray_byte <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (arb_any) begin
            state      <= TX;
            busy       <= 1'b1;
            grant_id   <= arb_id;
            grant_oh   <= arb_grant;
            rr_ptr     <= (arb_id == ID_MAX) ? '0 : arb_id + 1'b1;
            first_byte <= 1'b1;
          end
        end
        TX: begin
          if (accept) begin
            first_byte <= 1'b0;
            if (first_byte) begin
              rsp_len <= sel_len;
            end
            if (sel_last) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (pop) begin
            if (rsp_len == '0) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= RSP;
              timer <= '0;
            end
          end
        end
        RSP: begin
          if (rd_phy_fifo_en) begin
            rsp_valid <= grant_oh;
            rsp_data  <= rd_phy_fifo_data;
            timer     <= '0;
            if (rsp_len <= RSP_LEN_WIDTH'(1)) begin
              rsp_len  <= '0;
              rsp_last <= 1'b1;
              state    <= IDLE;
              busy     <= 1'b0;
            end else begin
              rsp_len <= rsp_len - 1'b1;
            end
          end else if (timer == TMR_LAST) begin
            rsp_timeout <= 1'b1;
            rsp_last    <= 1'b1;
            state       <= IDLE;
            busy        <= 1'b0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
